lsu_mem_ctrl: RTL and testbench

LSU_MEM_CTRL -- requirements
Module: lsu_mem_ctrl

---
 rtl/mem_pkg.sv | 29 ++
 rtl/lsu_lane_align.sv | 52 +++++
 rtl/lsu_mem_ctrl.sv | 139 +++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the load/store unit: FSM state encoding, access-size
// codes and the alignment rule used to reject requests before touching the RAM.
package mem_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_RMW_RD = 3'd2,
    ST_WRITE  = 3'd3,
    ST_RESP   = 3'd4
  } state_t;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

  // True when the access is misaligned for its size, or the size code is illegal.
  function automatic logic access_bad(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SIZE_B:  bad = 1'b0;
      SIZE_H:  bad = addr_lo[0];
      SIZE_W:  bad = (addr_lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane datapath for the load/store unit. Purely combinational:
//  - load side: picks the addressed byte/half out of the RAM word and
//    sign- or zero-extends it to 32 bits;
//  - store side: splices the low bits of the store data into the word read
//    back from the RAM, so a sub-word store can be written as a full word.
module lsu_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  i_off,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [31:0] i_rword,
  input  logic [31:0] i_merge,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_load,
  output logic [31:0] o_store
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rword[{i_off, 3'b000} +: 8];
  assign w_half = i_off[1] ? i_rword[31:16] : i_rword[15:0];

  // Load extraction and extension; a word load passes the RAM word straight through.
  always_comb begin
    o_load = i_rword;
    case (i_size)
      SIZE_B:  o_load = {{24{~i_unsigned & w_byte[7]}}, w_byte};
      SIZE_H:  o_load = {{16{~i_unsigned & w_half[15]}}, w_half};
      default: o_load = i_rword;
    endcase
  end

  // Store merge; a word store ignores the merge buffer entirely.
  always_comb begin
    o_store = i_wdata;
    case (i_size)
      SIZE_B: begin
        o_store = i_merge;
        o_store[{i_off, 3'b000} +: 8] = i_wdata[7:0];
      end
      SIZE_H: begin
        o_store = i_merge;
        if (i_off[1]) o_store[31:16] = i_wdata[15:0];
        else          o_store[15:0]  = i_wdata[15:0];
      end
      default: o_store = i_wdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller in front of a single-port data RAM with a
// combinational read port and a clocked write port.
//
// Handshake: a request transfers on a rising clk edge where
// req_valid && req_ready; req_ready is high only in IDLE, so at most one
// access is in flight. Completion is a single-cycle resp_valid pulse with no
// backpressure; resp_err and resp_rdata are meaningful only while resp_valid=1.
//
// Flow: IDLE -> LOAD -> RESP            (loads)
//       IDLE -> WRITE -> RESP           (word stores)
//       IDLE -> RMW_RD -> WRITE -> RESP (byte/half stores, read-modify-write)
//       IDLE -> RESP                    (misaligned or illegal size, no RAM access)
// dbg_state and dbg_addr expose the FSM state and latched address for checkers.
module lsu_mem_ctrl
  import mem_pkg::*;
#(
  parameter int ADDR_BITS = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [31:0]          req_addr,
  input  logic [1:0]           req_size,
  input  logic                 req_unsigned,
  input  logic [31:0]          req_wdata,
  output logic                 resp_valid,
  output logic                 resp_err,
  output logic [31:0]          resp_rdata,
  output logic [ADDR_BITS-1:0] ram_a,
  output logic                 ram_we,
  output logic [31:0]          ram_d,
  input  logic [31:0]          ram_spo,
  output logic [2:0]           dbg_state,
  output logic [31:0]          dbg_addr
);

  state_t      r_state;
  state_t      w_next;

  logic        r_we;
  logic [31:0] r_addr;
  logic [1:0]  r_size;
  logic        r_uns;
  logic [31:0] r_wdata;
  logic [31:0] r_merge;
  logic [31:0] r_rdata;
  logic        r_err;

  logic        w_accept;
  logic        w_req_bad;
  logic        w_ram_active;
  logic [31:0] w_load;
  logic [31:0] w_store;

  assign w_accept  = req_valid && (r_state == ST_IDLE);
  assign w_req_bad = access_bad(req_size, req_addr[1:0]);

  lsu_lane_align u_align (
    .i_off      (r_addr[1:0]),
    .i_size     (r_size),
    .i_unsigned (r_uns),
    .i_rword    (ram_spo),
    .i_merge    (r_merge),
    .i_wdata    (r_wdata),
    .o_load     (w_load),
    .o_store    (w_store)
  );

  // State register; reset wins over everything, including a pending write.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state: requests are routed at acceptance from the live inputs.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          if (w_req_bad)              w_next = ST_RESP;
          else if (!req_we)           w_next = ST_LOAD;
          else if (req_size == SIZE_W) w_next = ST_WRITE;
          else                        w_next = ST_RMW_RD;
        end
      end
      ST_LOAD:   w_next = ST_RESP;
      ST_RMW_RD: w_next = ST_WRITE;
      ST_WRITE:  w_next = ST_RESP;
      ST_RESP:   w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Request capture, load result and RMW merge buffer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_size  <= SIZE_B;
      r_uns   <= 1'b0;
      r_wdata <= '0;
      r_merge <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we    <= req_we;
        r_addr  <= req_addr;
        r_size  <= req_size;
        r_uns   <= req_unsigned;
        r_wdata <= req_wdata;
        r_err   <= w_req_bad;
        // Stores and rejected requests report zero data.
        r_rdata <= '0;
      end
      if (r_state == ST_LOAD)   r_rdata <= w_load;
      if (r_state == ST_RMW_RD) r_merge <= ram_spo;
    end
  end

  // Output decode; everything is forced to its idle value while rst_n is low.
  always_comb begin
    w_ram_active = (r_state == ST_LOAD) || (r_state == ST_RMW_RD) || (r_state == ST_WRITE);
    req_ready    = !rst_n || (r_state == ST_IDLE);
    resp_valid   = rst_n && (r_state == ST_RESP);
    resp_err     = resp_valid && r_err;
    resp_rdata   = rst_n ? r_rdata : 32'd0;
    ram_a        = (rst_n && w_ram_active) ? r_addr[ADDR_BITS+1:2] : '0;
    ram_we       = rst_n && (r_state == ST_WRITE) && r_we;
    ram_d        = ram_we ? w_store : 32'd0;
  end

  assign dbg_state = r_state;
  assign dbg_addr  = r_addr;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a behavioural RAM model.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
module tb_lsu_mem_ctrl;

  localparam int AB = 16;

  logic          clk;
  logic          rst_n;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [31:0]   req_addr;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic          resp_err;
  logic [31:0]   resp_rdata;
  logic [AB-1:0] ram_a;
  logic          ram_we;
  logic [31:0]   ram_d;
  logic [31:0]   ram_spo;
  logic [2:0]    dbg_state;
  logic [31:0]   dbg_addr;

  logic [31:0] mem [0:(1<<AB)-1];
  int n_pass;
  int n_total;
  int we_cnt;
  int we_base;

  lsu_mem_ctrl #(.ADDR_BITS(AB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_err     (resp_err),
    .resp_rdata   (resp_rdata),
    .ram_a        (ram_a),
    .ram_we       (ram_we),
    .ram_d        (ram_d),
    .ram_spo      (ram_spo),
    .dbg_state    (dbg_state),
    .dbg_addr     (dbg_addr)
  );

  // Clock and RAM model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign ram_spo = mem[ram_a];

  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_a] <= ram_d;
      we_cnt = we_cnt + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic drive(input logic v, input logic we, input logic [31:0] a,
                       input logic [1:0] sz, input logic uns, input logic [31:0] wd);
    req_valid    = v;
    req_we       = we;
    req_addr     = a;
    req_size     = sz;
    req_unsigned = uns;
    req_wdata    = wd;
  endtask

  // Load through the full sequence: accept, LOAD at T+1, RESP at T+2, IDLE after.
  task automatic do_load(input string tag, input logic [31:0] a, input logic [1:0] sz,
                         input logic uns, input logic [31:0] exp_word_a, input logic [31:0] exp_data);
    drive(1'b1, 1'b0, a, sz, uns, 32'h0);
    check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    tick();
    drive(1'b0, 1'b1, 32'hFFFF_FFFF, 2'd3, ~uns, 32'hFFFF_FFFF);
    check({tag, "_ram_a"}, {16'd0, ram_a}, exp_word_a);
    check({tag, "_we_t1"}, {31'd0, ram_we}, 32'd0);
    check({tag, "_vld_t1"}, {31'd0, resp_valid}, 32'd0);
    tick();
    check({tag, "_vld_t2"}, {31'd0, resp_valid}, 32'd1);
    check({tag, "_err"}, {31'd0, resp_err}, 32'd0);
    check({tag, "_rdata"}, resp_rdata, exp_data);
    tick();
    check({tag, "_vld_end"}, {31'd0, resp_valid}, 32'd0);
    check({tag, "_ready_end"}, {31'd0, req_ready}, 32'd1);
  endtask

  // Rejected request: RESP with error at T+1 and no RAM traffic.
  task automatic do_bad(input string tag, input logic we, input logic [31:0] a, input logic [1:0] sz);
    we_base = we_cnt;
    drive(1'b1, we, a, sz, 1'b0, 32'h5A5A_5A5A);
    tick();
    drive(1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0);
    check({tag, "_vld_t1"}, {31'd0, resp_valid}, 32'd1);
    check({tag, "_err_t1"}, {31'd0, resp_err}, 32'd1);
    check({tag, "_rdata"}, resp_rdata, 32'd0);
    check({tag, "_ram_a"}, {16'd0, ram_a}, 32'd0);
    check({tag, "_ram_we"}, {31'd0, ram_we}, 32'd0);
    tick();
    check({tag, "_vld_end"}, {31'd0, resp_valid}, 32'd0);
    check({tag, "_no_write"}, we_cnt - we_base, 32'd0);
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    we_cnt  = 0;
    for (int i = 0; i < (1 << AB); i++) mem[i] = 32'h0;
    mem[16'h40] = 32'h80FF7F01;
    mem[16'h42] = 32'h11111111;
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0);

    // Reset values
    tick();
    tick();
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_err", {31'd0, resp_err}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_ram_we", {31'd0, ram_we}, 32'd0);
    check("rst_ram_a", {16'd0, ram_a}, 32'd0);
    check("rst_ram_d", ram_d, 32'd0);
    rst_n = 1'b1;
    tick();
    check("idle_ready", {31'd0, req_ready}, 32'd1);

    // Loads from word 0x40 = 0x80FF7F01
    do_load("ldb_s_101", 32'h101, 2'd0, 1'b0, 32'h40, 32'h0000007F);
    do_load("ldb_s_103", 32'h103, 2'd0, 1'b0, 32'h40, 32'hFFFFFF80);
    do_load("ldh_s_102", 32'h102, 2'd1, 1'b0, 32'h40, 32'hFFFF80FF);
    do_load("ldh_u_102", 32'h102, 2'd1, 1'b1, 32'h40, 32'h000080FF);
    do_load("ldw_100",   32'h100, 2'd2, 1'b0, 32'h40, 32'h80FF7F01);

    // Byte store 0xAA at 0x102: RMW_RD at T+1, single write at T+2, RESP at T+3
    we_base = we_cnt;
    drive(1'b1, 1'b1, 32'h102, 2'd0, 1'b0, 32'h1234_56AA);
    tick();
    drive(1'b0, 1'b1, 32'h200, 2'd2, 1'b0, 32'h5555_5555);
    check("stb_t1_we", {31'd0, ram_we}, 32'd0);
    check("stb_t1_a", {16'd0, ram_a}, 32'h40);
    tick();
    check("stb_t2_we", {31'd0, ram_we}, 32'd1);
    check("stb_t2_a", {16'd0, ram_a}, 32'h40);
    check("stb_t2_d", ram_d, 32'h80AA7F01);
    check("stb_t2_vld", {31'd0, resp_valid}, 32'd0);
    tick();
    check("stb_t3_vld", {31'd0, resp_valid}, 32'd1);
    check("stb_t3_err", {31'd0, resp_err}, 32'd0);
    check("stb_t3_rdata", resp_rdata, 32'd0);
    check("stb_t3_we", {31'd0, ram_we}, 32'd0);
    check("stb_we_pulses", we_cnt - we_base, 32'd1);
    check("stb_mem", mem[16'h40], 32'h80AA7F01);
    tick();

    // Half store 0xBEEF at 0x100 -> 0x80AABEEF
    drive(1'b1, 1'b1, 32'h100, 2'd1, 1'b0, 32'hCAFE_BEEF);
    tick();
    drive(1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0);
    tick();
    check("sth_d", ram_d, 32'h80AABEEF);
    tick();
    check("sth_vld", {31'd0, resp_valid}, 32'd1);
    tick();

    // Word store to 0x104: WRITE at T+1, RESP at T+2
    drive(1'b1, 1'b1, 32'h104, 2'd2, 1'b0, 32'h1234_5678);
    tick();
    drive(1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0);
    check("stw_t1_we", {31'd0, ram_we}, 32'd1);
    check("stw_t1_a", {16'd0, ram_a}, 32'h41);
    check("stw_t1_d", ram_d, 32'h12345678);
    tick();
    check("stw_t2_vld", {31'd0, resp_valid}, 32'd1);
    check("stw_t2_rdata", resp_rdata, 32'd0);
    tick();
    do_load("ldw_104", 32'h104, 2'd2, 1'b0, 32'h41, 32'h12345678);

    // Upper address bits are dropped: 0x40100 maps to word 0x40
    do_load("ldw_wrap", 32'h0004_0100, 2'd2, 1'b0, 32'h40, 32'h80AABEEF);

    // Rejected requests
    do_bad("err_ldw_102", 1'b0, 32'h102, 2'd2);
    do_bad("err_size3", 1'b0, 32'h100, 2'd3);
    do_bad("err_sth_103", 1'b1, 32'h103, 2'd1);
    check("err_mem_kept", mem[16'h40], 32'h80AABEEF);

    // Reset asserted while in WRITE: no write, no response
    we_base = we_cnt;
    drive(1'b1, 1'b1, 32'h108, 2'd2, 1'b0, 32'hDEAD_BEEF);
    tick();
    drive(1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0);
    check("rstw_in_write", {31'd0, ram_we}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rstw_we_gated", {31'd0, ram_we}, 32'd0);
    check("rstw_ready", {31'd0, req_ready}, 32'd1);
    check("rstw_vld", {31'd0, resp_valid}, 32'd0);
    check("rstw_ram_d", ram_d, 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    check("rstw_mem", mem[16'h42], 32'h11111111);
    check("rstw_no_pulse", we_cnt - we_base, 32'd0);
    tick();
    check("rstw_vld_after", {31'd0, resp_valid}, 32'd0);
    check("rstw_ready_after", {31'd0, req_ready}, 32'd1);

    // Back-to-back with req_valid held high
    drive(1'b1, 1'b0, 32'h100, 2'd0, 1'b1, 32'h0);
    tick();
    check("b2b_a_busy", {31'd0, req_ready}, 32'd0);
    drive(1'b1, 1'b0, 32'h102, 2'd1, 1'b1, 32'h0);
    tick();
    check("b2b_a_vld", {31'd0, resp_valid}, 32'd1);
    check("b2b_a_rdata", resp_rdata, 32'h000000EF);
    check("b2b_a_ready", {31'd0, req_ready}, 32'd0);
    tick();
    check("b2b_idle_vld", {31'd0, resp_valid}, 32'd0);
    check("b2b_idle_ready", {31'd0, req_ready}, 32'd1);
    tick();
    check("b2b_b_busy", {31'd0, req_ready}, 32'd0);
    check("b2b_b_ram_a", {16'd0, ram_a}, 32'h40);
    drive(1'b0, 1'b0, 32'h0, 2'd0, 1'b0, 32'h0);
    tick();
    check("b2b_b_vld", {31'd0, resp_valid}, 32'd1);
    check("b2b_b_rdata", resp_rdata, 32'h000080AA);
    tick();
    check("b2b_end_vld", {31'd0, resp_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
